// File: rtl/threshold_table_loader_pkg.sv
// Shared definitions for the threshold table loader and the comparator that
// consumes its table.
//   - tl_state_e      : loader FSM states
//   - calc_cnt_width  : RAM address/data width derived from VECTOR_WIDTH
//   - SAT_MAX         : all-ones RAM word for the default configuration
package threshold_table_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } tl_state_e;

    function automatic int calc_cnt_width(input int vector_width);
        return $clog2(vector_width);
    endfunction

    localparam int VECTOR_WIDTH_DEF = 920;
    localparam int CNT_WIDTH        = calc_cnt_width(VECTOR_WIDTH_DEF);
    localparam int SAT_MAX          = (1 << CNT_WIDTH) - 1;

endpackage

// File: rtl/threshold_table_loader_ceil_sat_shift.sv
// ceil_sat_shift: combinational conversion of the fixed-point accumulator to
// a table entry, entry = ceil(acc / 2^FRAC_WIDTH), clamped to all-ones.
//   acc_i   : accumulator value (ACC_W bits, FRAC_WIDTH fractional)
//   entry_o : rounded-up integer entry, saturated to CNT_WIDTH bits
//   sat_o   : high when the unclamped entry does not fit in CNT_WIDTH bits
module ceil_sat_shift #(
    parameter int ACC_W      = 27,
    parameter int FRAC_WIDTH = 8,
    parameter int CNT_WIDTH  = 10
) (
    input  logic [ACC_W-1:0]     acc_i,
    output logic [CNT_WIDTH-1:0] entry_o,
    output logic                 sat_o
);
    localparam logic [ACC_W:0] ROUND = (ACC_W+1)'((1 << FRAC_WIDTH) - 1);
    localparam logic [ACC_W:0] LIMIT = (ACC_W+1)'((1 << CNT_WIDTH) - 1);

    // One spare bit so adding the rounding constant can never wrap.
    logic [ACC_W:0] sum;
    logic [ACC_W:0] shifted;

    always_comb begin
        sum     = {1'b0, acc_i} + ROUND;
        shifted = sum >> FRAC_WIDTH;
        sat_o   = (shifted > LIMIT);
        entry_o = sat_o ? '1 : shifted[CNT_WIDTH-1:0];
    end

endmodule

// File: rtl/threshold_table_loader.sv
// threshold_table_loader: writes ceil(C*K) (saturated) for C = 0..VECTOR_WIDTH
// into the comparator's threshold RAM, one entry per cycle, using only an
// accumulator add.
//   clk, rst            : clock, asynchronous active-high reset
//   i_Start, i_Coef     : build request and coefficient K (sampled together)
//   i_Abort             : cancel an in-progress build
//   o_BRAM_Addr/Din     : RAM write address (= C) and entry value
//   o_BRAM_En/WrEn      : RAM enable and write strobe (always equal)
//   o_Busy              : table being written, compare datapath invalid
//   o_Done              : one-cycle pulse after a complete build
module threshold_table_loader
    import threshold_table_loader_pkg::*;
#(
    parameter int VECTOR_WIDTH = 920,
    parameter int FRAC_WIDTH   = 8,
    parameter int COEF_WIDTH   = 16,
    parameter int CNT_WIDTH    = calc_cnt_width(VECTOR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_Start,
    input  logic [COEF_WIDTH-1:0] i_Coef,
    input  logic                  i_Abort,
    output logic [CNT_WIDTH-1:0]  o_BRAM_Addr,
    output logic [CNT_WIDTH-1:0]  o_BRAM_Din,
    output logic                  o_BRAM_En,
    output logic                  o_BRAM_WrEn,
    output logic                  o_Busy,
    output logic                  o_Done
);
    localparam int ACC_W = CNT_WIDTH + COEF_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH);

    // The address counter must be able to hold VECTOR_WIDTH itself.
    if (VECTOR_WIDTH >= (1 << CNT_WIDTH)) begin : g_bad_width
        $error("VECTOR_WIDTH must be below 2**CNT_WIDTH");
    end

    tl_state_e             state_q, state_d;
    logic [COEF_WIDTH-1:0] coef_q,  coef_d;
    logic [ACC_W-1:0]      acc_q,   acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic                  sat_q,   sat_d;
    logic [CNT_WIDTH-1:0]  addr_q,  addr_d;
    logic [CNT_WIDTH-1:0]  din_q,   din_d;
    logic                  wren_q,  wren_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic [CNT_WIDTH-1:0]  entry;
    logic                  entry_sat;

    ceil_sat_shift #(
        .ACC_W      (ACC_W),
        .FRAC_WIDTH (FRAC_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ceil_sat_shift (
        .acc_i   (acc_q),
        .entry_o (entry),
        .sat_o   (entry_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            coef_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            coef_q  <= coef_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wren_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Abort has no meaning here, so Start wins when both are set.
                if (i_Start) begin
                    state_d = WRITE;
                    coef_d  = i_Coef;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            WRITE: begin
                if (i_Abort) begin
                    state_d = IDLE;
                end else begin
                    addr_d = cnt_q;
                    // ACC only grows, so once saturated every later entry is too.
                    din_d  = (sat_q || entry_sat) ? '1 : entry;
                    sat_d  = sat_q | entry_sat;
                    wren_d = 1'b1;
                    busy_d = 1'b1;
                    acc_d  = acc_q + ACC_W'(coef_q);
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_BRAM_Addr = addr_q;
    assign o_BRAM_Din  = din_q;
    assign o_BRAM_En   = wren_q;
    assign o_BRAM_WrEn = wren_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;

endmodule
